// File: rtl/servo_cmd_pkg.sv
// rtl/servo_cmd_pkg.sv - shared constants, state encoding and frame sizing for servo_cmd_decoder
package servo_cmd_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_EMIT = 3'd4
  } state_t;

  // Number of payload bytes needed to carry a position of the given width.
  function automatic int data_bytes(input int resolution);
    return (resolution + 7) / 8;
  endfunction

endpackage

// File: rtl/servo_cmd_timeout.sv
// rtl/servo_cmd_timeout.sv - inter-byte idle timer: reloads on clr or when disabled, expire pulses after TimeoutCycles idle cycles
module servo_cmd_timeout #(
  parameter int TimeoutCycles = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TimeoutCycles);
  localparam logic [CW-1:0] LOAD = CW'(TimeoutCycles - 1);

  logic [CW-1:0] cnt;

  // A clear in the expiry cycle suppresses the expiry: the byte wins.
  assign expire = en && !clr && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || !en) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/servo_cmd_decoder.sv
// rtl/servo_cmd_decoder.sv - byte-stream to servo write framer; optional checksum byte under SERVO_CMD_CHECKSUM_EN
module servo_cmd_decoder
  import servo_cmd_pkg::*;
#(
  parameter int Resolution    = 8,
  parameter int AddressWidth  = 2,
  parameter int TimeoutCycles = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    ce,
  output logic [Resolution-1:0]   data,
  output logic [AddressWidth-1:0] addr,
  output logic                    frame_ok,
  output logic                    frame_err
);

  localparam int DB = data_bytes(Resolution);
  localparam int SW = DB * 8;
  localparam int BW = (DB > 1) ? $clog2(DB) : 1;
  localparam logic [BW-1:0] LAST = BW'(DB - 1);

  state_t                state, state_next;
  logic                  accept, expire, timer_en, last_byte, addr_ok;
  logic                  frame_done, frame_bad;
  logic [7:0]            shadow_addr;
  logic [SW-1:0]         shadow_data, shadow_next;
  logic [BW-1:0]         byte_cnt;
  logic [Resolution-1:0] emit_data;

  assign accept      = in_valid && in_ready;
  assign timer_en    = (state != ST_IDLE) && (state != ST_EMIT);
  assign last_byte   = (byte_cnt == LAST);
  assign addr_ok     = (shadow_addr >> AddressWidth) == 8'd0;
  assign shadow_next = (shadow_data << 8) | SW'(in_data);

`ifdef SERVO_CMD_CHECKSUM_EN
  logic [7:0] chk;
  logic       chk_ok;

  assign chk_ok     = (chk == in_data);
  assign frame_done = accept && (state == ST_CHK) && chk_ok;
  assign frame_bad  = accept && (state == ST_CHK) && !chk_ok;
  assign emit_data  = shadow_data[Resolution-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      chk <= 8'd0;
    end else if (accept && state == ST_ADDR) begin
      chk <= in_data;
    end else if (accept && state == ST_DATA) begin
      chk <= chk ^ in_data;
    end
  end
`else
  // Outputs are loaded as the final byte arrives so they are valid during the EMIT cycle.
  assign frame_done = accept && (state == ST_DATA) && last_byte;
  assign frame_bad  = 1'b0;
  assign emit_data  = shadow_next[Resolution-1:0];
`endif

  servo_cmd_timeout #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (timer_en),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (accept && in_data == HEADER_BYTE) state_next = ST_ADDR;
      ST_ADDR: if (accept) state_next = ST_DATA;
      ST_DATA: if (accept && last_byte) begin
`ifdef SERVO_CMD_CHECKSUM_EN
        state_next = ST_CHK;
`else
        state_next = ST_EMIT;
`endif
      end
`ifdef SERVO_CMD_CHECKSUM_EN
      ST_CHK:  if (accept) state_next = chk_ok ? ST_EMIT : ST_IDLE;
`else
      ST_CHK:  state_next = ST_IDLE;
`endif
      ST_EMIT: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (expire) state_next = ST_IDLE;
  end

  always_comb begin
    in_ready = !rst && (state != ST_EMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_addr <= 8'd0;
      shadow_data <= '0;
      byte_cnt    <= '0;
      ce          <= 1'b0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      addr        <= '0;
      data        <= '0;
    end else begin
      ce        <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (accept && state == ST_ADDR) begin
        shadow_addr <= in_data;
        byte_cnt    <= '0;
      end
      if (accept && state == ST_DATA) begin
        shadow_data <= shadow_next;
        byte_cnt    <= byte_cnt + BW'(1);
      end
      if (frame_done) begin
        if (addr_ok) begin
          ce       <= 1'b1;
          frame_ok <= 1'b1;
          addr     <= shadow_addr[AddressWidth-1:0];
          data     <= emit_data;
        end else begin
          frame_err <= 1'b1;
        end
      end
      if (expire || frame_bad) frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_servo_cmd_decoder.sv
// tb/tb_servo_cmd_decoder.sv - self-checking bench: vector table, timeout/reset sequences, randomized stream vs frame model
module tb_servo_cmd_decoder;

  localparam int RES = 8;
  localparam int AW  = 2;
  localparam int TO  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready, ce, frame_ok, frame_err;
  logic [RES-1:0] data;
  logic [AW-1:0]  addr;

  int errors = 0;
  int checks = 0;
  int obs[$];
  int exp_q[$];
  int ce_count = 0;
  int err_count = 0;
  bit prev_ce = 1'b0;
  bit prev_err = 1'b0;

  typedef struct {
    int          n;
    logic [47:0] bytes;
    int          exp_ce;
    int          exp_addr;
    int          exp_data;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  servo_cmd_decoder #(
    .Resolution   (RES),
    .AddressWidth (AW),
    .TimeoutCycles(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ce       (ce),
    .data     (data),
    .addr     (addr),
    .frame_ok (frame_ok),
    .frame_err(frame_err)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 4) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_byte: in_ready stuck low for byte %0h", b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Pulse rules observed on every active cycle; also records write/error events.
  always @(negedge clk) begin
    if (ce) begin
      obs.push_back(int'(addr) * 256 + int'(data));
      ce_count++;
    end
    if (frame_err) begin
      obs.push_back(-1);
      err_count++;
    end
    if (ce || frame_ok || frame_err) begin
      checks++;
      if (ce !== frame_ok || (ce && frame_err) || (ce && prev_ce) || (frame_err && prev_err)) begin
        errors++;
        $display("FAIL pulse_rules: ce=%0b frame_ok=%0b frame_err=%0b prev_ce=%0b prev_err=%0b required ce==frame_ok, single-cycle, exclusive",
                 ce, frame_ok, frame_err, prev_ce, prev_err);
      end
    end
    prev_ce  = ce;
    prev_err = frame_err;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ce0, err0;
    bit in_frame;
    logic [7:0] cur[$];

    vecs[0] = '{3, 48'hFF025A000000, 1, 2, 'h5A};
    vecs[1] = '{5, 48'h1377FF03FF00, 1, 3, 'hFF};
    vecs[2] = '{3, 48'hFF0410000000, 0, 3, 'hFF};
    vecs[3] = '{3, 48'hFF0080000000, 1, 0, 'h80};
    vecs[4] = '{3, 48'hFFFFFF000000, 0, 0, 'h80};
    vecs[5] = '{4, 48'h55FF01000000, 1, 1, 'h00};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_outputs", {ce, frame_ok, frame_err, addr, data}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // Vector table: back-to-back bytes, check the cycle after the last byte
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].bytes[47 - 8*k -: 8]);
      @(negedge clk);
      check($sformatf("vec%0d_ce", i), ce, vecs[i].exp_ce);
      check($sformatf("vec%0d_frame_ok", i), frame_ok, vecs[i].exp_ce);
      check($sformatf("vec%0d_frame_err", i), frame_err, 1 - vecs[i].exp_ce);
      check($sformatf("vec%0d_in_ready", i), in_ready, 0);
      check($sformatf("vec%0d_addr", i), addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
      @(negedge clk);
      check($sformatf("vec%0d_pulse_end", i), {ce, frame_err}, 0);
    end

    // Timeout: 16 idle cycles inside a frame
    send_byte(8'hFF);
    send_byte(8'h01);
    idle(15);
    @(negedge clk);
    check("to_before_expiry", frame_err, 0);
    @(negedge clk);
    check("to_frame_err", frame_err, 1);
    check("to_no_ce", ce, 0);
    check("to_hold_out", {addr, data}, {2'd1, 8'h00});
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'h80);
    @(negedge clk);
    check("to_next_ce", ce, 1);
    check("to_next_out", {addr, data}, {2'd0, 8'h80});

    // Byte accepted in the expiry cycle wins
    err0 = err_count;
    send_byte(8'hFF);
    send_byte(8'h02);
    idle(15);
    send_byte(8'h33);
    @(negedge clk);
    check("edge_ce", ce, 1);
    check("edge_out", {addr, data}, {2'd2, 8'h33});
    check("edge_no_err", err_count - err0, 0);

    // Reset mid-frame: silent abort, outputs cleared
    send_byte(8'hFF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out", {ce, frame_ok, frame_err, addr, data}, 0);
    ce0  = ce_count;
    err0 = err_count;
    send_byte(8'h01);
    send_byte(8'h22);
    idle(20);
    check("mid_rst_no_ce", ce_count - ce0, 0);
    check("mid_rst_no_err", err_count - err0, 0);

    // Randomized stream against a frame-level model
    obs.delete();
    exp_q.delete();
    in_frame = 1'b0;
    for (int i = 0; i < 400; i++) begin
      int g, r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      g = (r < 60) ? 0 : (r < 85) ? $urandom_range(1, 4) : (r < 93) ? 15 : $urandom_range(16, 20);
      r = $urandom_range(0, 9);
      b = (r < 3) ? 8'hFF : (r < 6) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      idle(g);
      send_byte(b);
      if (in_frame && g >= TO) begin
        exp_q.push_back(-1);
        in_frame = 1'b0;
      end
      if (!in_frame) begin
        if (b == 8'hFF) begin
          in_frame = 1'b1;
          cur.delete();
        end
      end else begin
        cur.push_back(b);
        if (cur.size() == 2) begin
          if (cur[0] < 4) exp_q.push_back(int'(cur[0]) * 256 + int'(cur[1]));
          else            exp_q.push_back(-1);
          in_frame = 1'b0;
        end
      end
    end
    idle(20);
    if (in_frame) exp_q.push_back(-1);

    check("rand_event_count", obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
      check($sformatf("rand_event%0d", i), obs[i], exp_q[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
